// File: rtl/deser_pkg.sv
// Shared types, default parameters and helpers for the deserializer lane alignment sequencer.
package deser_pkg;

  localparam int unsigned NUM_LANES_DEF    = 12;
  localparam int unsigned DEV_W_DEF        = 8;
  localparam int unsigned WORD_SIZE_DEF    = 24;
  localparam logic [23:0] TRAIN_PATTERN_DEF = 24'hFFF000;
  localparam int unsigned MATCH_CNT_DEF    = 16;
  localparam int unsigned SETTLE_WORDS_DEF = 4;
  localparam int unsigned TIMEOUT_CYC_DEF  = 4096;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_SLIP,
    ST_NEXT,
    ST_DONE
  } align_state_e;

  // Number of byte-rotation phases in an assembled word.
  function automatic int unsigned byte_phases(input int unsigned word_size, input int unsigned dev_w);
    return word_size / dev_w;
  endfunction

  // Bitslip budget per lane: every bit position of every byte phase, less the starting one.
  function automatic int unsigned max_attempts(input int unsigned word_size, input int unsigned dev_w);
    return dev_w * (word_size / dev_w) - 1;
  endfunction

  // Byte phase advance with wrap.
  function automatic logic [1:0] next_phase(input logic [1:0] phase, input int unsigned phases);
    return (32'(phase) + 32'd1 >= phases) ? 2'd0 : phase + 2'd1;
  endfunction

endpackage

// File: rtl/deser_word_match.sv
// Selects the lane under training, compares its word against the training pattern and
// counts consecutive matches while the sequencer is checking.
module deser_word_match
  import deser_pkg::*;
#(
  parameter int unsigned NUM_LANES = NUM_LANES_DEF,
  parameter int unsigned WORD_SIZE = WORD_SIZE_DEF,
  parameter logic [WORD_SIZE-1:0] TRAIN_PATTERN = WORD_SIZE'(TRAIN_PATTERN_DEF),
  parameter int unsigned MATCH_CNT = MATCH_CNT_DEF,
  parameter int unsigned LANE_W    = 4
) (
  input  logic                           clk_div,
  input  logic                           rst_n,
  input  logic                           check_en,
  input  logic                           word_valid,
  input  logic [NUM_LANES*WORD_SIZE-1:0] lane_word,
  input  logic [LANE_W-1:0]              lane_sel,
  output logic                           word_eq_c,
  output logic                           lock_hit_c
);

  localparam int unsigned MC_W = $clog2(MATCH_CNT + 1);

  logic [MC_W-1:0]      match_cnt;
  logic [WORD_SIZE-1:0] word_c;

  assign word_c     = lane_word[32'(lane_sel)*WORD_SIZE +: WORD_SIZE];
  assign word_eq_c  = (word_c == TRAIN_PATTERN);
  assign lock_hit_c = check_en && word_valid && word_eq_c &&
                      (match_cnt == MC_W'(MATCH_CNT - 1));

  // Consecutive-match counter; any mismatch or leaving CHECK restarts it.
  always_ff @(posedge clk_div) begin
    if (!rst_n || !check_en) begin
      match_cnt <= '0;
    end else if (word_valid) begin
      if (!word_eq_c || lock_hit_c) begin
        match_cnt <= '0;
      end else begin
        match_cnt <= match_cnt + MC_W'(1);
      end
    end
  end

endmodule

// File: rtl/deser_align_ctrl.sv
// Link-training sequencer: walks every deserializer lane, slips bits and byte phases until
// the training pattern is seen MATCH_CNT times in a row, and reports per-lane lock or fail.
module deser_align_ctrl
  import deser_pkg::*;
#(
  parameter int unsigned NUM_LANES    = NUM_LANES_DEF,
  parameter int unsigned DEV_W        = DEV_W_DEF,
  parameter int unsigned WORD_SIZE    = WORD_SIZE_DEF,
  parameter logic [WORD_SIZE-1:0] TRAIN_PATTERN = WORD_SIZE'(TRAIN_PATTERN_DEF),
  parameter int unsigned MATCH_CNT    = MATCH_CNT_DEF,
  parameter int unsigned SETTLE_WORDS = SETTLE_WORDS_DEF,
  parameter int unsigned TIMEOUT_CYC  = TIMEOUT_CYC_DEF,
  localparam int unsigned LANE_W      = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                           clk_div,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [NUM_LANES*WORD_SIZE-1:0] lane_word,
  input  logic                           word_valid,
  output logic [NUM_LANES-1:0]           bitslip,
  output logic [NUM_LANES*2-1:0]         byte_phase,
  output logic                           busy,
  output logic                           done,
  output logic [NUM_LANES-1:0]           lane_locked,
  output logic [NUM_LANES-1:0]           lane_fail,
  output logic [LANE_W-1:0]              cur_lane
);

  localparam int unsigned PHASES  = byte_phases(WORD_SIZE, DEV_W);
  localparam int unsigned MAX_ATT = max_attempts(WORD_SIZE, DEV_W);
  localparam int unsigned ATT_W   = $clog2(MAX_ATT + 1);
  localparam int unsigned SET_W   = $clog2(SETTLE_WORDS + 1);
  localparam int unsigned TO_W    = $clog2(TIMEOUT_CYC);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);

  align_state_e      state;
  logic [LANE_W-1:0] lane;
  logic [ATT_W-1:0]  attempt;
  logic [SET_W-1:0]  settle_cnt;
  logic [TO_W-1:0]   to_cnt;

  logic              word_eq_c;
  logic              lock_hit_c;
  logic              timeout_c;
  logic [ATT_W-1:0]  attempt_nxt_c;
  logic [1:0]        phase_cur_c;

  assign cur_lane      = lane;
  assign attempt_nxt_c = attempt + ATT_W'(1);
  assign timeout_c     = !word_valid && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
  assign phase_cur_c   = byte_phase[32'(lane)*2 +: 2];

  deser_word_match #(
    .NUM_LANES     (NUM_LANES),
    .WORD_SIZE     (WORD_SIZE),
    .TRAIN_PATTERN (TRAIN_PATTERN),
    .MATCH_CNT     (MATCH_CNT),
    .LANE_W        (LANE_W)
  ) u_match (
    .clk_div    (clk_div),
    .rst_n      (rst_n),
    .check_en   (state == ST_CHECK),
    .word_valid (word_valid),
    .lane_word  (lane_word),
    .lane_sel   (lane),
    .word_eq_c  (word_eq_c),
    .lock_hit_c (lock_hit_c)
  );

  // Sequencer: state, counters and all per-lane outputs.
  always_ff @(posedge clk_div) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      lane        <= '0;
      attempt     <= '0;
      settle_cnt  <= '0;
      to_cnt      <= '0;
      bitslip     <= '0;
      byte_phase  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      lane_locked <= '0;
      lane_fail   <= '0;
    end else begin
      bitslip <= '0;
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            lane_locked <= '0;
            lane_fail   <= '0;
            byte_phase  <= '0;
            lane        <= '0;
            attempt     <= '0;
            settle_cnt  <= '0;
            to_cnt      <= '0;
            busy        <= 1'b1;
            done        <= 1'b0;
            state       <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (word_valid) begin
            to_cnt <= '0;
            if (settle_cnt == SET_W'(SETTLE_WORDS - 1)) begin
              settle_cnt <= '0;
              state      <= ST_CHECK;
            end else begin
              settle_cnt <= settle_cnt + SET_W'(1);
            end
          end else if (timeout_c) begin
            lane_fail[lane] <= 1'b1;
            to_cnt          <= '0;
            state           <= ST_NEXT;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        ST_CHECK: begin
          if (word_valid) begin
            to_cnt <= '0;
            if (lock_hit_c) begin
              lane_locked[lane] <= 1'b1;
              state             <= ST_NEXT;
            end else if (!word_eq_c) begin
              if (32'(attempt) < MAX_ATT) begin
                // Pulse goes out during the SLIP cycle; every DEV_W slips rotate one byte.
                bitslip <= NUM_LANES'(1) << lane;
                attempt <= attempt_nxt_c;
                if (32'(attempt_nxt_c) % DEV_W == 32'd0) begin
                  byte_phase[32'(lane)*2 +: 2] <= next_phase(phase_cur_c, PHASES);
                end
                state <= ST_SLIP;
              end else begin
                lane_fail[lane] <= 1'b1;
                state           <= ST_NEXT;
              end
            end
          end else if (timeout_c) begin
            lane_fail[lane] <= 1'b1;
            to_cnt          <= '0;
            state           <= ST_NEXT;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        ST_SLIP: begin
          settle_cnt <= '0;
          to_cnt     <= '0;
          state      <= ST_SETTLE;
        end
        ST_NEXT: begin
          settle_cnt <= '0;
          to_cnt     <= '0;
          if (lane == LAST_LANE) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            lane    <= lane + LANE_W'(1);
            attempt <= '0;
            state   <= ST_SETTLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_deser_align_ctrl.sv
// Directed bench for deser_align_ctrl: per-lane deserializer models that present the
// training pattern once a lane has received its required number of bitslips.
module tb_deser_align_ctrl;

  localparam int NL = 12;
  localparam int WS = 24;
  localparam logic [WS-1:0] PAT = 24'hFFF000;
  localparam logic [WS-1:0] BAD = 24'h000FFF;
  localparam int NEVER = 1000;

  logic            clk_div = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            word_valid = 1'b0;
  logic [NL*WS-1:0] lane_word;
  logic [NL-1:0]   bitslip;
  logic [2*NL-1:0] byte_phase;
  logic            busy;
  logic            done;
  logic [NL-1:0]   lane_locked;
  logic [NL-1:0]   lane_fail;
  logic [3:0]      cur_lane;

  int need  [NL];
  int base  [NL];
  int slips [NL];
  int viol;
  logic prev_slip = 1'b0;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_div = ~clk_div;

  deser_align_ctrl dut (
    .clk_div     (clk_div),
    .rst_n       (rst_n),
    .start       (start),
    .lane_word   (lane_word),
    .word_valid  (word_valid),
    .bitslip     (bitslip),
    .byte_phase  (byte_phase),
    .busy        (busy),
    .done        (done),
    .lane_locked (lane_locked),
    .lane_fail   (lane_fail),
    .cur_lane    (cur_lane)
  );

  // Lane model: pattern appears once the lane has seen its required slip count this run.
  always_comb begin
    for (int i = 0; i < NL; i++) begin
      lane_word[i*WS +: WS] = ((slips[i] - base[i]) == need[i]) ? PAT : BAD;
    end
  end

  // Pulse counter plus one-hot / non-back-to-back watcher.
  always @(negedge clk_div) begin
    if ($countones(bitslip) > 1) viol <= viol + 1;
    else if (bitslip != '0 && prev_slip) viol <= viol + 1;
    prev_slip <= |bitslip;
    for (int i = 0; i < NL; i++) begin
      if (bitslip[i]) slips[i] <= slips[i] + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic new_run();
    for (int i = 0; i < NL; i++) begin
      need[i] = 0;
      base[i] = slips[i];
    end
  endtask

  task automatic pulse_start();
    @(negedge clk_div) start = 1'b1;
    @(negedge clk_div) start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    while (!done && cyc < budget) begin
      @(negedge clk_div);
      cyc++;
    end
    if (!done) check("done_timeout", 64'(done), 64'd1);
  endtask

  function automatic int run_slips(input int lane);
    return slips[lane] - base[lane];
  endfunction

  task automatic check_idle_zero(input string tag);
    check({tag, "_bitslip"}, 64'(bitslip), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_locked"}, 64'(lane_locked), 64'd0);
    check({tag, "_fail"}, 64'(lane_fail), 64'd0);
    check({tag, "_phase"}, 64'(byte_phase), 64'd0);
    check({tag, "_lane"}, 64'(cur_lane), 64'd0);
  endtask

  initial begin
    int cyc;
    int other;
    int s7;

    viol = 0;
    new_run();
    word_valid = 1'b1;
    repeat (3) @(negedge clk_div);
    check_idle_zero("reset");
    rst_n = 1'b1;
    @(negedge clk_div);

    // Every lane aligned from the first word.
    new_run();
    pulse_start();
    check("t1_busy", 64'(busy), 64'd1);
    wait_done(2000, cyc);
    check("t1_cycles", 64'(cyc), 64'd252);
    check("t1_locked", 64'(lane_locked), 64'hFFF);
    check("t1_fail", 64'(lane_fail), 64'd0);
    check("t1_busy_end", 64'(busy), 64'd0);
    other = 0;
    for (int i = 0; i < NL; i++) other += run_slips(i);
    check("t1_slips", 64'(other), 64'd0);

    // Lane 3 needs 10 slips, lane 5 never aligns; a start while busy is ignored.
    new_run();
    need[3] = 10;
    need[5] = NEVER;
    pulse_start();
    check("t6_clr_locked", 64'(lane_locked), 64'd0);
    check("t6_clr_done", 64'(done), 64'd0);
    check("t6_restart_lane", 64'(cur_lane), 64'd0);
    cyc = 0;
    while (cur_lane != 4'd4 && cyc < 5000) begin
      @(negedge clk_div);
      cyc++;
    end
    check("t6_reach_lane4", 64'(cur_lane), 64'd4);
    start = 1'b1;
    @(negedge clk_div) start = 1'b0;
    check("t6_busy_start_lane", 64'(cur_lane), 64'd4);
    check("t6_busy_start_busy", 64'(busy), 64'd1);
    wait_done(20000, cyc);
    check("t2_slips3", 64'(run_slips(3)), 64'd10);
    check("t3_slips5", 64'(run_slips(5)), 64'd23);
    check("t23_phase", 64'(byte_phase), 64'h000840);
    check("t23_locked", 64'(lane_locked), 64'hFDF);
    check("t23_fail", 64'(lane_fail), 64'h020);
    other = 0;
    for (int i = 0; i < NL; i++) if (i != 3 && i != 5) other += run_slips(i);
    check("t23_other_slips", 64'(other), 64'd0);
    check("t23_onehot", 64'(viol), 64'd0);

    // Valid words stop during lane 0 CHECK.
    new_run();
    pulse_start();
    repeat (4) @(negedge clk_div);
    word_valid = 1'b0;
    cyc = 0;
    while (!lane_fail[0] && cyc < 5000) begin
      @(negedge clk_div);
      cyc++;
    end
    check("t4_timeout_cycles", 64'(cyc), 64'd4096);
    @(negedge clk_div);
    check("t4_lane_adv", 64'(cur_lane), 64'd1);
    word_valid = 1'b1;
    wait_done(2000, cyc);
    check("t4_fail", 64'(lane_fail), 64'h001);
    check("t4_locked", 64'(lane_locked), 64'hFFE);

    // Reset while lane 7 is slipping.
    new_run();
    need[7] = 5;
    pulse_start();
    cyc = 0;
    while (!bitslip[7] && cyc < 3000) begin
      @(negedge clk_div);
      cyc++;
    end
    check("t5_slip7_seen", 64'(bitslip), 64'h080);
    check("t5_locked_before", 64'(lane_locked), 64'h07F);
    rst_n = 1'b0;
    @(negedge clk_div);
    check_idle_zero("t5_reset");
    rst_n = 1'b1;
    s7 = slips[7];
    repeat (100) @(negedge clk_div);
    check("t5_no_more_slips", 64'(slips[7] - s7), 64'd0);
    check("t5_still_idle", 64'(busy), 64'd0);
    check("t5_onehot", 64'(viol), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
